// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control unit for the 32-bit multicycle processor. A Moore state machine walks
// each instruction through fetch, decode, execute, memory and writeback
// cycles. It drives every datapath mux select and write enable, and produces
// the 3-bit ALU operation code.
//
// Ports
//   clk        in   rising-edge clock shared with the datapath
//   rst_n      in   asynchronous active-low reset
//   Op         in   instruction[31:26] from the instruction register
//   Funct      in   instruction[5:0] from the instruction register
//   Zero       in   combinational zero flag from the ALU
//   IorD       out  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  data memory write enable
//   IRWrite    out  instruction register load
//   PCEn       out  PC load = PCWrite | (Branch & Zero)
//   RegDst     out  write register select (0 = rt, 1 = rd)
//   MemtoReg   out  writeback data select (0 = ALUOut, 1 = memory data)
//   RegWrite   out  register file write enable
//   ALUSrcA    out  ALU A source (0 = PC, 1 = A register)
//   ALUSrcB    out  ALU B source (00 B, 01 4, 10 signext imm, 11 imm<<2)
//   PCSrc      out  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   ALUControl out  ALU operation (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
// -----------------------------------------------------------------------------
module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCEn,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUControl
);

   // State encoding
   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMRD    = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWR    = 4'd5;
   localparam logic [3:0] EXECUTE  = 4'd6;
   localparam logic [3:0] ALUWB    = 4'd7;
   localparam logic [3:0] BRANCH   = 4'd8;
   localparam logic [3:0] ADDIEXEC = 4'd9;
   localparam logic [3:0] ADDIWB   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   logic [3:0] state_q, state_d;

   // Raw (pre-reset-gating) enables decoded from the state
   logic ir_write_raw;
   logic pc_write;
   logic branch;
   logic mem_write_raw;
   logic reg_write_raw;

   logic [2:0] alu_funct;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic. Op is only consulted in DECODE and MEMADR.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               // Unknown opcode: drop the instruction and refetch.
               default:      state_d = FETCH;
            endcase
         end
         // Only lw and sw reach MEMADR, so anything other than lw is a store.
         MEMADR:   state_d = (Op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         EXECUTE:  state_d = ALUWB;
         ADDIEXEC: state_d = ADDIWB;
         MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
         // Unused encodings recover to FETCH.
         default:  state_d = FETCH;
      endcase
   end

   // --------------------------------------------------------------------------
   // R-type funct decode. Unknown functs fall back to add and still write back.
   // --------------------------------------------------------------------------
   always_comb begin
      alu_funct = ALU_ADD;
      case (Funct)
         FN_ADD:  alu_funct = ALU_ADD;
         FN_SUB:  alu_funct = ALU_SUB;
         FN_AND:  alu_funct = ALU_AND;
         FN_OR:   alu_funct = ALU_OR;
         FN_SLT:  alu_funct = ALU_SLT;
         default: alu_funct = ALU_ADD;
      endcase
   end

   // --------------------------------------------------------------------------
   // Moore output decode
   // --------------------------------------------------------------------------
   always_comb begin
      ir_write_raw  = 1'b0;
      pc_write      = 1'b0;
      branch        = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      IorD          = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      PCSrc         = 2'b00;
      ALUControl    = ALU_ADD;
      case (state_q)
         FETCH: begin
            // PC + 4 straight from the ALU result into the PC
            ir_write_raw = 1'b1;
            pc_write     = 1'b1;
            ALUSrcB      = 2'b01;
         end
         DECODE: begin
            // Precompute the branch target into ALUOut
            ALUSrcB = 2'b11;
         end
         MEMADR, ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         MEMRD: begin
            IorD = 1'b1;
         end
         MEMWB: begin
            reg_write_raw = 1'b1;
            MemtoReg      = 1'b1;
         end
         MEMWR: begin
            IorD          = 1'b1;
            mem_write_raw = 1'b1;
         end
         EXECUTE: begin
            ALUSrcA    = 1'b1;
            ALUControl = alu_funct;
         end
         ALUWB: begin
            reg_write_raw = 1'b1;
            RegDst        = 1'b1;
         end
         BRANCH: begin
            // Compare A and B; target taken from ALUOut computed in DECODE
            ALUSrcA    = 1'b1;
            ALUControl = ALU_SUB;
            PCSrc      = 2'b01;
            branch     = 1'b1;
         end
         ADDIWB: begin
            reg_write_raw = 1'b1;
         end
         JUMP: begin
            pc_write = 1'b1;
            PCSrc    = 2'b10;
         end
         default: ;
      endcase
   end

   // Enables are held off for the whole reset interval, independent of the
   // clock, so no write can slip through while the state is being forced.
   assign IRWrite  = rst_n & ir_write_raw;
   assign MemWrite = rst_n & mem_write_raw;
   assign RegWrite = rst_n & reg_write_raw;
   assign PCEn     = rst_n & (pc_write | (branch & Zero));

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit for the 32-bit multicycle processor. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath mux select and write enable, and produces the 3-bit `ALUControl` code consumed directly by the ALU's operation select. It sits upstream of the ALU and register file and downstream of the instruction register, whose `Op`/`Funct` fields it reads.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock shared with the datapath.
- `rst_n` input 1: asynchronous, active-low reset.
- `Op` input 6: instruction[31:26] from the instruction register.
- `Funct` input 6: instruction[5:0] from the instruction register.
- `Zero` input 1: combinational zero flag from the ALU.
- `IorD` output 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` output 1: data memory write enable.
- `IRWrite` output 1: instruction register load.
- `PCEn` output 1: PC load, equal to `PCWrite | (Branch & Zero)`.
- `RegDst` output 1: write register select (0 = rt, 1 = rd).
- `MemtoReg` output 1: writeback data select (0 = ALUOut, 1 = memory data).
- `RegWrite` output 1: register file write enable.
- `ALUSrcA` output 1: ALU A source (0 = PC, 1 = A register).
- `ALUSrcB` output 2: ALU B source (00 = B reg, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2).
- `PCSrc` output 2: next-PC select (00 = ALUResult, 01 = ALUOut, 10 = jump target).
- `ALUControl` output 3: ALU operation code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).

## Operation
- State register, 4 bits; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw 100011, sw 101011), EXECUTE (R-type 000000), BRANCH (beq 000100), ADDIEXEC (addi 001000), JUMP (j 000010).
  - Any other opcode: DECODE→FETCH; no write enable asserted.
  - MEMADR→MEMRD (lw) or MEMWR (sw); MEMRD→MEMWB.
  - EXECUTE→ALUWB; ADDIEXEC→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Outputs decode only from the state, except the `Zero` term in `PCEn`. Unlisted enables are 0; unlisted selects are 0 and ALUControl is 010.
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - DECODE: ALUSrcB=11, ALUControl=010 (branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALU add.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALU add.
  - ADDIWB: RegWrite=1, RegDst=0.
  - JUMP: PCWrite=1, PCSrc=10.
- Funct decode in EXECUTE: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010, and writeback still occurs.
- `Op` and `Funct` are sampled only in DECODE, MEMADR and EXECUTE. Changes in other states are ignored.

## Timing
- On `rst_n` low: state = FETCH immediately, asynchronously. While `rst_n` = 0, all enables (IRWrite, PCEn, MemWrite, RegWrite) are forced 0. Selects hold their FETCH values.
- First active fetch is on the first rising edge after `rst_n` deasserts.
- Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.
- ALUOut is registered inside the ALU. A value computed in state S is read by the datapath in state S+1 (MEMADR→MEMRD/MEMWR, EXECUTE→ALUWB, ADDIEXEC→ADDIWB).
- `PCEn` in BRANCH is combinational on `Zero` within the same cycle. A `Zero` glitch before the clock edge is tolerated; only the settled value matters.
- Reset asserted mid-instruction aborts it. No write enable remains asserted after `rst_n` falls, and the next instruction restarts at FETCH.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → state FETCH, IRWrite=PCEn=MemWrite=RegWrite=0. Release → first edge asserts IRWrite=1, PCEn=1, ALUSrcB=01.
- R-type sweep: Op=000000 with Funct 100000/100010/100100/100101/101010 → EXECUTE shows ALUControl 010/110/000/001/111. The following cycle shows RegWrite=1, RegDst=1; 4 cycles per instruction.
- lw then sw: Op=100011 → 5 cycles with IorD=1 in MEMRD and RegWrite=1, MemtoReg=1 in MEMWB. Op=101011 → 4 cycles with MemWrite=1 for exactly one cycle.
- beq: Zero=1 → PCEn=1, PCSrc=01 in BRANCH. Zero=0 → PCEn=0. Both take 3 cycles.
- addi, j, illegal: Op=001000 → RegWrite=1, RegDst=0 in cycle 4. Op=000010 → PCEn=1, PCSrc=10 in cycle 3. Op=111111 → back to FETCH after 2 cycles with no writes.
- Reset mid-lw: drop `rst_n` during MEMRD → RegWrite never asserts; after release, sequencing restarts at FETCH.
